aoc2_range_splitter: RTL and testbench

Sequencer in front of the day-2 invalid-ID datapath. Accepts one inclusive ID range [lo, hi] at a time and emits it as a stream of sub-ranges, each confined to a single decimal digit count, tagged with that count. The digit-count encoder and prefix lookup stage can then process each sub-range without ever crossing a power-of-ten boundary. Sits between the input parser and the per-digit-count sum engine.

---
 rtl/aoc2_range_splitter_if.sv | 30 +++
 rtl/aoc2_range_splitter.sv | 187 ++++++++++++++++++
 tb/tb_aoc2_range_splitter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aoc2_range_splitter_if.sv
// rtl/aoc2_range_splitter_if.sv - range-in / sub-range-out handshake bundle for aoc2_range_splitter
//
// in_valid/in_ready/in_lo/in_hi      : inclusive ID range offered by the parser
// out_valid/out_ready/out_lo/out_hi  : single-digit-count sub-range to the sum engine
// out_digs/out_last                  : digit count of the sub-range, final sub-range flag
// master : range source / sub-range sink side; slave : the splitter
interface aoc2_range_splitter_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_lo;
  logic [DATA_WIDTH-1:0] in_hi;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_lo;
  logic [DATA_WIDTH-1:0] out_hi;
  logic [3:0]            out_digs;
  logic                  out_last;

  modport master (
    output in_valid, in_lo, in_hi, out_ready,
    input  in_ready, out_valid, out_lo, out_hi, out_digs, out_last
  );

  modport slave (
    input  in_valid, in_lo, in_hi, out_ready,
    output in_ready, out_valid, out_lo, out_hi, out_digs, out_last
  );
endinterface

// File: rtl/aoc2_range_splitter.sv
// rtl/aoc2_range_splitter.sv - splits an inclusive ID range into sub-ranges of constant decimal digit count
//
// clk, rst_n  : rising-edge clock, asynchronous active-low reset
// rs          : aoc2_range_splitter_if slave (range in, sub-range out)
// range_done  : one-cycle pulse when a range has been fully handled
// range_err   : one-cycle pulse when a range is rejected (lo > hi or hi >= 10^MAX_DIGS)
// ranges_cnt  : count of completed, non-rejected ranges (wraps)
// Optional feature macro AOC2_SKIP_ODD_EN: sub-ranges with an odd digit count are dropped.
module aoc2_range_splitter #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_DIGS   = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  aoc2_range_splitter_if.slave        rs,
  output logic                        range_done,
  output logic                        range_err,
  output logic [31:0]                 ranges_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] pow10(input int n);
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(1);
    for (int i = 0; i < n; i++) p = p * DATA_WIDTH'(10);
    return p;
  endfunction

  // Priority encoder: the highest power of ten not exceeding v sets the count; 0 reports 1 digit.
  function automatic logic [3:0] get_digs(input logic [DATA_WIDTH-1:0] v);
    logic [3:0] d;
    d = 4'd1;
    for (int i = 1; i < MAX_DIGS; i++) begin
      if (v >= pow10(i)) d = 4'(i + 1);
    end
    return d;
  endfunction

  // Largest value with d digits, i.e. 10^d - 1.
  function automatic logic [DATA_WIDTH-1:0] digs_top(input logic [3:0] d);
    logic [DATA_WIDTH-1:0] t;
    t = pow10(MAX_DIGS) - DATA_WIDTH'(1);
    for (int i = 1; i <= MAX_DIGS; i++) begin
      if (d == 4'(i)) t = pow10(i) - DATA_WIDTH'(1);
    end
    return t;
  endfunction

  localparam logic [DATA_WIDTH-1:0] HI_LIMIT = pow10(MAX_DIGS);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_lo_q, out_lo_d;
  logic [DATA_WIDTH-1:0] out_hi_q, out_hi_d;
  logic [3:0]            out_digs_q, out_digs_d;
  logic                  out_last_q, out_last_d;
  logic                  range_done_q, range_done_d;
  logic                  range_err_q, range_err_d;
  logic [31:0]           ranges_cnt_q, ranges_cnt_d;

  logic [3:0]            calc_digs;
  logic [DATA_WIDTH-1:0] calc_lim;
  logic [DATA_WIDTH-1:0] calc_top;
  logic                  calc_skip;

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    hi_d         = hi_q;
    out_valid_d  = out_valid_q;
    out_lo_d     = out_lo_q;
    out_hi_d     = out_hi_q;
    out_digs_d   = out_digs_q;
    out_last_d   = out_last_q;
    range_done_d = 1'b0;
    range_err_d  = 1'b0;
    ranges_cnt_d = ranges_cnt_q;

    calc_digs = get_digs(cur_q);
    calc_lim  = digs_top(calc_digs);
    calc_top  = (hi_q < calc_lim) ? hi_q : calc_lim;
`ifdef AOC2_SKIP_ODD_EN
    calc_skip = calc_digs[0];
`else
    calc_skip = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (rs.in_valid) begin
          cur_d = rs.in_lo;
          hi_d  = rs.in_hi;
          if ((rs.in_lo > rs.in_hi) || (rs.in_hi >= HI_LIMIT)) begin
            range_err_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (calc_skip) begin
          // Dropped sub-range: either the range is finished or we walk to the next decade here.
          if (calc_top == hi_q) begin
            state_d      = IDLE;
            range_done_d = 1'b1;
            ranges_cnt_d = ranges_cnt_q + 32'd1;
          end else begin
            cur_d = calc_top + DATA_WIDTH'(1);
          end
        end else begin
          out_lo_d    = cur_q;
          out_hi_d    = calc_top;
          out_digs_d  = calc_digs;
          out_last_d  = (calc_top == hi_q);
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end

      EMIT: begin
        if (rs.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d      = IDLE;
            range_done_d = 1'b1;
            ranges_cnt_d = ranges_cnt_q + 32'd1;
          end else begin
            cur_d   = out_hi_q + DATA_WIDTH'(1);
            state_d = CALC;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      hi_q         <= '0;
      out_valid_q  <= 1'b0;
      out_lo_q     <= '0;
      out_hi_q     <= '0;
      out_digs_q   <= 4'd0;
      out_last_q   <= 1'b0;
      range_done_q <= 1'b0;
      range_err_q  <= 1'b0;
      ranges_cnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      hi_q         <= hi_d;
      out_valid_q  <= out_valid_d;
      out_lo_q     <= out_lo_d;
      out_hi_q     <= out_hi_d;
      out_digs_q   <= out_digs_d;
      out_last_q   <= out_last_d;
      range_done_q <= range_done_d;
      range_err_q  <= range_err_d;
      ranges_cnt_q <= ranges_cnt_d;
    end
  end

  assign rs.in_ready  = (state_q == IDLE);
  assign rs.out_valid = out_valid_q;
  assign rs.out_lo    = out_lo_q;
  assign rs.out_hi    = out_hi_q;
  assign rs.out_digs  = out_digs_q;
  assign rs.out_last  = out_last_q;
  assign range_done   = range_done_q;
  assign range_err    = range_err_q;
  assign ranges_cnt   = ranges_cnt_q;

endmodule

// File: tb/tb_aoc2_range_splitter.sv
// tb/tb_aoc2_range_splitter.sv - scoreboard bench for aoc2_range_splitter
module tb_aoc2_range_splitter;

  localparam int DW = 64;
`ifdef AOC2_SKIP_ODD_EN
  localparam bit SKIP_ODD = 1'b1;
`else
  localparam bit SKIP_ODD = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
    logic [3:0]  digs;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        range_done;
  logic        range_err;
  logic [31:0] ranges_cnt;

  aoc2_range_splitter_if #(.DATA_WIDTH(DW)) rs ();

  aoc2_range_splitter #(.DATA_WIDTH(DW), .MAX_DIGS(11)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs         (rs),
    .range_done (range_done),
    .range_err  (range_err),
    .ranges_cnt (ranges_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t       sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          beats_seen = 0;
  int          last_hs_cyc = 0;
  logic        last_beat_was_last = 1'b0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: walk decades by repeated multiplication, push every beat the DUT should emit.
  task automatic push_range(input logic [63:0] lo, input logic [63:0] hi);
    logic [63:0] cur, top, p;
    int d;
    cur = lo;
    forever begin
      d = 1;
      p = 64'd10;
      while (cur >= p) begin
        d++;
        p = p * 64'd10;
      end
      top = (hi < p - 64'd1) ? hi : p - 64'd1;
      if (!(SKIP_ODD && (d % 2 == 1))) sb.push_back('{lo: cur, hi: top, digs: 4'(d), last: (top == hi)});
      if (top == hi) break;
      cur = top + 64'd1;
    end
  endtask

  // Output monitor: compare each handshaken beat against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rs.out_valid && rs.out_ready) begin
      beat_t e;
      beats_seen++;
      last_hs_cyc = cyc;
      last_beat_was_last = rs.out_last;
      if (sb.size() == 0) begin
        check_eq("extra_beat", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("beat_lo", rs.out_lo, e.lo);
        check_eq("beat_hi", rs.out_hi, e.hi);
        check_eq("beat_digs", 64'(rs.out_digs), 64'(e.digs));
        check_eq("beat_last", 64'(rs.out_last), 64'(e.last));
      end
    end
  end

  task automatic drive_range(input logic [63:0] lo, input logic [63:0] hi);
    @(posedge clk);
    #1;
    rs.in_valid = 1'b1;
    rs.in_lo    = lo;
    rs.in_hi    = hi;
    @(posedge clk);
    #1;
    rs.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (range_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check_eq({tag, "_in_ready_at_done"}, 64'(rs.in_ready), 64'd1);
      check_eq({tag, "_cnt"}, 64'(ranges_cnt), 64'(exp_cnt));
      check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
      if (last_beat_was_last) check_eq({tag, "_done_lat"}, 64'(cyc), 64'(last_hs_cyc + 1));
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 64'(range_done), 64'd0);
    end
  endtask

  task automatic wait_out_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rs.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_valid_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic run_simple(input string tag, input logic [63:0] lo, input logic [63:0] hi);
    push_range(lo, hi);
    exp_cnt = exp_cnt + 32'd1;
    drive_range(lo, hi);
    wait_done(tag);
  endtask

  task automatic run_reject(input string tag, input logic [63:0] lo, input logic [63:0] hi);
    bit any_valid;
    any_valid = 1'b0;
    drive_range(lo, hi);
    @(negedge clk);
    check_eq({tag, "_err"}, 64'(range_err), 64'd1);
    check_eq({tag, "_ready"}, 64'(rs.in_ready), 64'd1);
    @(negedge clk);
    check_eq({tag, "_err_pulse"}, 64'(range_err), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (rs.out_valid) any_valid = 1'b1;
      @(negedge clk);
    end
    check_eq({tag, "_no_valid"}, 64'(any_valid), 64'd0);
    check_eq({tag, "_cnt"}, 64'(ranges_cnt), 64'(exp_cnt));
  endtask

  initial begin
    logic [63:0] s_lo, s_hi;
    logic [3:0]  s_digs;
    logic        s_last;

    rs.in_valid  = 1'b0;
    rs.in_lo     = '0;
    rs.in_hi     = '0;
    rs.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 64'(rs.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(rs.out_valid), 64'd0);
    check_eq("rst_out_lo", rs.out_lo, 64'd0);
    check_eq("rst_done", 64'(range_done), 64'd0);
    check_eq("rst_err", 64'(range_err), 64'd0);
    check_eq("rst_cnt", 64'(ranges_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 11..22: single beat, first out_valid two edges after acceptance
    push_range(64'd11, 64'd22);
    exp_cnt = exp_cnt + 32'd1;
    drive_range(64'd11, 64'd22);
    @(negedge clk);
    check_eq("t1_valid_n1", 64'(rs.out_valid), 64'd0);
    @(negedge clk);
    check_eq("t1_valid_n2", 64'(rs.out_valid), 64'd1);
    wait_done("t1");
    check_eq("t1_cnt_one", 64'(ranges_cnt), 64'd1);

    run_simple("t2", 64'd95, 64'd115);

    beats_seen = 0;
    run_simple("t3", 64'd1, 64'd100000);
    check_eq("t3_beats", 64'(beats_seen), SKIP_ODD ? 64'd3 : 64'd6);

    run_simple("t_zero", 64'd0, 64'd15);

    run_reject("t4a", 64'd5, 64'd3);
    run_reject("t4b", 64'd5, 64'd100000000000);

    // Backpressure: first beat must hold while out_ready is low; in_valid is ignored meanwhile.
    rs.out_ready = 1'b0;
    push_range(64'd998, 64'd1012);
    exp_cnt = exp_cnt + 32'd1;
    drive_range(64'd998, 64'd1012);
    wait_out_valid("t5");
    s_lo   = rs.out_lo;
    s_hi   = rs.out_hi;
    s_digs = rs.out_digs;
    s_last = rs.out_last;
    if (sb.size() > 0) begin
      check_eq("t5_first_lo", s_lo, sb[0].lo);
      check_eq("t5_first_hi", s_hi, sb[0].hi);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      rs.in_valid = 1'b1;
      rs.in_lo    = 64'(i + 1);
      rs.in_hi    = 64'(i + 50);
      @(negedge clk);
      check_eq("t5_hold_valid", 64'(rs.out_valid), 64'd1);
      check_eq("t5_hold_lo", rs.out_lo, s_lo);
      check_eq("t5_hold_hi", rs.out_hi, s_hi);
      check_eq("t5_hold_digs", 64'(rs.out_digs), 64'(s_digs));
      check_eq("t5_hold_last", 64'(rs.out_last), 64'(s_last));
      check_eq("t5_busy", 64'(rs.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rs.in_valid  = 1'b0;
    rs.out_ready = 1'b1;
    wait_done("t5");

    // Reset in the middle of a range discards it.
    rs.out_ready = 1'b0;
    drive_range(64'd1, 64'd100000);
    wait_out_valid("t6");
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 64'(rs.out_valid), 64'd0);
    check_eq("t6_rst_done", 64'(range_done), 64'd0);
    check_eq("t6_rst_cnt", 64'(ranges_cnt), 64'd0);
    check_eq("t6_rst_ready", 64'(rs.in_ready), 64'd1);
    sb.delete();
    exp_cnt = 32'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rs.out_ready = 1'b1;
    run_simple("t6_after", 64'd11, 64'd22);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
